// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying the program image into the loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory writer: unpacks a length-prefixed, XOR-checked
// byte image into 16-bit IM words and holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [15:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [7:0]  hi_byte;
  logic [7:0]  chk;
  logic        xfer;
  logic [15:0] n_rx;
  logic [15:0] wcnt_nx;

  assign s.in_ready = (state == LEN_HI)
                   || (state == LEN_LO)
                   || (state == DATA_HI)
                   || (state == DATA_LO)
                   || (state == CHK);
  assign busy    = s.in_ready;
  assign xfer    = s.in_valid && s.in_ready;
  assign n_rx    = {len_hi, s.in_data};
  assign wcnt_nx = wcnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_hi     <= '0;
      len        <= '0;
      wcnt       <= '0;
      hi_byte    <= '0;
      chk        <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            chk        <= '0;
            wcnt       <= '0;
            imem_waddr <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi <= s.in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= n_rx;
            if (n_rx == 16'd0) begin
              state <= CHK;
            end else if ({1'b0, n_rx} > DEPTH_L) begin
              // oversize image rejected before any IM write
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (xfer) begin
            hi_byte <= s.in_data;
            chk     <= chk ^ s.in_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            chk        <= chk ^ s.in_data;
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, s.in_data};
            imem_waddr <= wcnt[ADDR_W-1:0];
            wcnt       <= wcnt_nx;
            state      <= (wcnt_nx == len) ? CHK : DATA_HI;
          end
        end
        CHK: begin
          if (xfer) begin
            if (s.in_data == chk) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames built from word lists,
// expected IM writes queued at build time and popped by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader_if bs ();

  imem_loader #(
    .ADDR_W(8),
    .DEPTH (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s         (bs),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [23:0] exp_q[$];
  logic [15:0] words[$];
  logic [23:0] mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_we: got addr %0h data %0h expected no write",
                 imem_waddr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("imem_write", {8'h0, imem_waddr, imem_wdata}, {8'h0, mon_e});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit ok;
    ok = 1'b0;
    bs.in_valid = 1'b0;
    repeat (stall) tick();
    bs.in_valid = 1'b1;
    bs.in_data  = b;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bs.in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
    end else begin
      n_total++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 for byte %0h", b);
    end
    bs.in_valid = 1'b0;
  endtask

  function automatic int stall_of(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bs.in_ready), 32'd0);
    check({tag, "_we"},    32'(imem_we),     32'd0);
    check({tag, "_waddr"}, 32'(imem_waddr),  32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata),  32'd0);
    check({tag, "_crst"},  32'(core_rst),    32'd1);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_err"},   32'(err),         32'd0);
  endtask

  task automatic run_frame(input string tag, input bit bad, input int mode);
    logic [7:0]  fb[$];
    logic [7:0]  c;
    logic [15:0] n;
    c = 8'h00;
    n = 16'(words.size());
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    foreach (words[i]) begin
      fb.push_back(words[i][15:8]);
      fb.push_back(words[i][7:0]);
      c = c ^ words[i][15:8] ^ words[i][7:0];
      exp_q.push_back({8'(i), words[i]});
    end
    fb.push_back(bad ? (c ^ 8'h01) : c);
    pulse_start();
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_crst"}, 32'(core_rst), 32'd1);
    if (mode == 2) start = 1'b1;
    foreach (fb[i]) begin
      if (i == fb.size() - 1) start = 1'b0;
      send_byte(fb[i], stall_of(mode));
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(!bad));
    check({tag, "_err"},  32'(err),  32'(bad));
    check({tag, "_crst"}, 32'(core_rst), 32'(bad));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic load_test1_words;
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    words.push_back(16'h0F0F);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bs.in_valid = 1'b0;
    bs.in_data  = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    load_test1_words();
    run_frame("t1", 1'b0, 0);

    run_frame("badchk", 1'b1, 0);

    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("lenerr_err",   32'(err),         32'd1);
    check("lenerr_ready", 32'(bs.in_ready), 32'd0);
    check("lenerr_done",  32'(done),        32'd0);
    check("lenerr_crst",  32'(core_rst),    32'd1);
    bs.in_valid = 1'b1;
    bs.in_data  = 8'h5A;
    repeat (3) tick();
    bs.in_valid = 1'b0;
    @(negedge clk);
    check("lenerr_sticky", 32'(err), 32'd1);
    tick();

    run_frame("toggle", 1'b0, 1);
    run_frame("stall", 1'b0, 2);

    pulse_start();
    exp_q.push_back({8'd0, 16'h1234});
    exp_q.push_back({8'd1, 16'hABCD});
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h0F, 0);
    bs.in_valid = 1'b1;
    bs.in_data  = 8'h0F;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bs.in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    tick();
    run_frame("after_rst", 1'b0, 0);

    words.delete();
    run_frame("zero", 1'b0, 0);
    pulse_start();
    @(negedge clk);
    check("restart_crst", 32'(core_rst), 32'd1);
    check("restart_done", 32'(done),     32'd0);
    check("restart_busy", 32'(busy),     32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, 12));
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      run_frame("rand", bit'($urandom_range(0, 1)), 2);
    end

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
